// File: rtl/packed_mult_acc_dsp_pkg.sv
// Shared CNN datapath package.
// Holds the DSP48 port widths and the elaboration-time helpers that check
// lane packing and size the accumulation guard.
//   lane_ok        : 1 when DATA_W/LANES/LANE_SHIFT pack legally into one DSP
//   acc_safe_beats : number of beats a lane can accumulate with no possible
//                    overflow of its LANE_SHIFT-bit field
package cnn_pkg;

  localparam int DSP_A_W = 27;  // A/D pre-adder port width
  localparam int DSP_B_W = 18;  // B multiplier port width
  localparam int DSP_P_W = 48;  // P accumulator width

  function automatic bit lane_ok(input int data_w, input int lanes, input int lane_shift);
    return (data_w >= 2) && (data_w <= 8) &&
           (lanes >= 1) && (lanes <= 3) &&
           (lane_shift >= 2 * data_w + 1) &&
           ((lanes - 1) * lane_shift + data_w <= DSP_A_W) &&
           (lanes * lane_shift <= DSP_P_W);
  endfunction

  // A lane product magnitude is at most 2^(2*DATA_W-2); summing
  // 2^(LANE_SHIFT-2*DATA_W) of them reaches 2^(LANE_SHIFT-2), which still
  // fits a signed LANE_SHIFT-bit field.
  function automatic longint acc_safe_beats(input int data_w, input int lane_shift);
    return longint'(1) << (lane_shift - 2 * data_w);
  endfunction

endpackage

// File: rtl/packed_mult_acc_dsp_if.sv
// Beat/result bundle for packed_mult_acc_dsp.
//   master : producer side (drives in_*, a_vec, w; observes results)
//   slave  : the multiplier (consumes beats, drives out_valid/out_vec/acc_ovf)
// in_first/in_last frame accumulation groups; a_vec lane k is
// a_vec[k*DATA_W +: DATA_W]; out_vec lane k is out_vec[k*LANE_SHIFT +: LANE_SHIFT].
interface packed_mult_acc_dsp_if #(
  parameter int DATA_W     = 4,
  parameter int LANES      = 2,
  parameter int LANE_SHIFT = 11
);
  logic                          in_valid;
  logic                          in_first;
  logic                          in_last;
  logic [LANES*DATA_W-1:0]       a_vec;
  logic [DATA_W-1:0]             w;
  logic                          out_valid;
  logic [LANES*LANE_SHIFT-1:0]   out_vec;
  logic                          acc_ovf;

  modport master (
    output in_valid, in_first, in_last, a_vec, w,
    input  out_valid, out_vec, acc_ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, a_vec, w,
    output out_valid, out_vec, acc_ovf
  );
endinterface

// File: rtl/packed_mult_acc_dsp_unpack.sv
// packed_lane_unpack: splits a packed 48-bit DSP result into signed lanes.
// Each lane field sits at k*LANE_SHIFT; a negative lower lane borrows one
// from the field above it, so lane k>0 adds back bit k*LANE_SHIFT-1.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid, in_ovf  result strobe and overflow flag from the P stage
//   p                 packed DSP P word
//   out_valid         registered result strobe
//   out_vec           registered corrected lanes
//   out_ovf           registered overflow flag
module packed_lane_unpack
  import cnn_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int LANE_SHIFT = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_ovf,
  input  logic [DSP_P_W-1:0]          p,
  output logic                        out_valid,
  output logic [LANES*LANE_SHIFT-1:0] out_vec,
  output logic                        out_ovf
);

  logic [LANES*LANE_SHIFT-1:0] lane_fix;
  logic                        unused_p;

  // Bits above the top lane are not part of any result.
  assign unused_p = ^p;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi == 0) begin : g_base
      assign lane_fix[gi*LANE_SHIFT +: LANE_SHIFT] = p[gi*LANE_SHIFT +: LANE_SHIFT];
    end else begin : g_borrow
      assign lane_fix[gi*LANE_SHIFT +: LANE_SHIFT] =
        p[gi*LANE_SHIFT +: LANE_SHIFT] + LANE_SHIFT'(p[gi*LANE_SHIFT-1]);
    end
  end

  logic                        valid_d, valid_q;
  logic                        ovf_d, ovf_q;
  logic [LANES*LANE_SHIFT-1:0] vec_d, vec_q;

  always_comb begin
    valid_d = in_valid;
    ovf_d   = 1'b0;
    vec_d   = vec_q;
    if (in_valid) begin
      ovf_d = in_ovf;
      vec_d = lane_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      vec_q   <= vec_d;
    end
  end

  assign out_valid = valid_q;
  assign out_vec   = vec_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/packed_mult_acc_dsp.sv
// packed_mult_acc_dsp: LANES signed activations share one DSP48 multiply
// against a common signed weight, with optional per-lane accumulation.
// Pipeline (5 registers, beat -> out_valid in 5 cycles):
//   s1 lane words / weight, s2 pre-add, s3 multiply, s4 P (reg or acc),
//   s5 borrow-corrected unpack.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of packed_mult_acc_dsp_if (beats in, results out)
// Parameters: DATA_W operand width, LANES packed lanes, LANE_SHIFT lane
// spacing and output lane width, ACC_MODE 0 = per beat, 1 = framed groups.
module packed_mult_acc_dsp
  import cnn_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int LANES      = 2,
  parameter int LANE_SHIFT = 11,
  parameter int ACC_MODE   = 0
) (
  input  logic clk,
  input  logic rst,
  packed_mult_acc_dsp_if.slave bus
);

  if (!lane_ok(DATA_W, LANES, LANE_SHIFT) || (ACC_MODE < 0) || (ACC_MODE > 1)) begin : g_bad_cfg
    $error("packed_mult_acc_dsp: illegal DATA_W/LANES/LANE_SHIFT/ACC_MODE combination");
  end

  // Counter saturates one past the safe count, so two extra bits suffice.
  localparam int              CNT_W      = LANE_SHIFT - 2 * DATA_W + 2;
  localparam logic [CNT_W-1:0] SAFE_BEATS = CNT_W'(acc_safe_beats(DATA_W, LANE_SHIFT));

  // ---------------- stage 1: lane words and weight ----------------
  logic signed [DSP_A_W-1:0] lane_word_d [LANES];
  logic signed [DSP_A_W-1:0] lane_word_q [LANES];
  logic signed [DSP_B_W-1:0] w1_d, w1_q;
  logic                      v1_d, v1_q, f1_d, f1_q, l1_d, l1_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_word_d[k] = DSP_A_W'($signed(bus.a_vec[k*DATA_W +: DATA_W])) << (k * LANE_SHIFT);
    end
    w1_d = DSP_B_W'($signed(bus.w));
    v1_d = bus.in_valid;
    f1_d = bus.in_first;
    l1_d = bus.in_last;
  end

  // ---------------- stage 2: pre-adder ----------------
  logic signed [DSP_A_W-1:0] preadd_d, preadd_q;
  logic signed [DSP_B_W-1:0] w2_d, w2_q;
  logic                      v2_d, v2_q, f2_d, f2_q, l2_d, l2_q;

  always_comb begin
    preadd_d = '0;
    for (int k = 0; k < LANES; k++) begin
      preadd_d = preadd_d + lane_word_q[k];
    end
    w2_d = w1_q;
    v2_d = v1_q;
    f2_d = f1_q;
    l2_d = l1_q;
  end

  // ---------------- stage 3: multiply ----------------
  (* use_dsp = "yes" *) logic signed [DSP_P_W-1:0] prod_d, prod_q;
  logic                      v3_d, v3_q, f3_d, f3_q, l3_d, l3_q;

  always_comb begin
    prod_d = DSP_P_W'(preadd_q) * DSP_P_W'(w2_q);
    v3_d   = v2_q;
    f3_d   = f2_q;
    l3_d   = l2_q;
  end

  // ---------------- stage 4: P register / accumulator ----------------
  (* use_dsp = "yes" *) logic signed [DSP_P_W-1:0] p_d, p_q;
  logic [CNT_W-1:0]          cnt_d, cnt_q;
  logic                      open_d, open_q;
  logic                      v4_d, v4_q, ovf4_d, ovf4_q;

  always_comb begin
    p_d    = p_q;
    cnt_d  = cnt_q;
    open_d = open_q;
    v4_d   = 1'b0;
    ovf4_d = 1'b0;
    if (ACC_MODE == 0) begin
      if (v3_q) begin
        p_d = prod_q;
      end
      v4_d = v3_q;
    end else if (v3_q) begin
      // A beat starts a fresh group on first, or when no group is open
      // (a stray last behaves as first+last).
      if (f3_q || !open_q) begin
        p_d   = prod_q;
        cnt_d = CNT_W'(1);
      end else begin
        p_d = p_q + prod_q;
        if (cnt_q <= SAFE_BEATS) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      open_d = !l3_q;
      v4_d   = l3_q;
      ovf4_d = (cnt_d > SAFE_BEATS);
    end
  end

  always_ff @(posedge clk) begin
    lane_word_q <= lane_word_d;
    w1_q        <= w1_d;
    f1_q        <= f1_d;
    l1_q        <= l1_d;
    preadd_q    <= preadd_d;
    w2_q        <= w2_d;
    f2_q        <= f2_d;
    l2_q        <= l2_d;
    prod_q      <= prod_d;
    f3_q        <= f3_d;
    l3_q        <= l3_d;
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      ovf4_q <= 1'b0;
      p_q    <= '0;
      cnt_q  <= '0;
      open_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      v4_q   <= v4_d;
      ovf4_q <= ovf4_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      open_q <= open_d;
    end
  end

  // ---------------- stage 5: unpack ----------------
  packed_lane_unpack #(
    .LANES      (LANES),
    .LANE_SHIFT (LANE_SHIFT)
  ) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4_q),
    .in_ovf    (ovf4_q),
    .p         (p_q),
    .out_valid (bus.out_valid),
    .out_vec   (bus.out_vec),
    .out_ovf   (bus.acc_ovf)
  );

endmodule

// File: tb/tb_packed_mult_acc_dsp.sv
// Bench for packed_mult_acc_dsp: three instances (2-lane per-beat,
// 2-lane accumulating, 3-lane per-beat) against an arithmetic reference.
module tb_packed_mult_acc_dsp;
  localparam int DW  = 4;
  localparam int LS  = 11;
  localparam int VW  = 3 * LS;
  localparam int AW2 = 2 * DW;
  localparam int AW3 = 3 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  packed_mult_acc_dsp_if #(.DATA_W(DW), .LANES(2), .LANE_SHIFT(LS)) if0 ();
  packed_mult_acc_dsp_if #(.DATA_W(DW), .LANES(2), .LANE_SHIFT(LS)) if1 ();
  packed_mult_acc_dsp_if #(.DATA_W(DW), .LANES(3), .LANE_SHIFT(LS)) if2 ();

  packed_mult_acc_dsp #(.DATA_W(DW), .LANES(2), .LANE_SHIFT(LS), .ACC_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  packed_mult_acc_dsp #(.DATA_W(DW), .LANES(2), .LANE_SHIFT(LS), .ACC_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  packed_mult_acc_dsp #(.DATA_W(DW), .LANES(3), .LANE_SHIFT(LS), .ACC_MODE(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    int             due;
    logic [VW-1:0]  vec;
    bit             ovf;
    bit             chk_vec;
  } exp_t;

  exp_t exp_q [3][$];

  // Accumulating reference: running per-lane sums of a*w over the open group.
  bit m_open = 1'b0;
  int m_cnt  = 0;
  int m_sum0 = 0;
  int m_sum1 = 0;

  function automatic int rs();
    return int'($urandom_range(2 ** DW - 1)) - 2 ** (DW - 1);
  endfunction

  function automatic logic [VW-1:0] pack3(input int v0, input int v1, input int v2);
    return {v2[LS-1:0], v1[LS-1:0], v0[LS-1:0]};
  endfunction

  task automatic check_port(input int id, input logic ov, input logic [VW-1:0] vec, input logic ovf);
    exp_t e;
    if (exp_q[id].size() > 0 && exp_q[id][0].due == cyc) begin
      e = exp_q[id].pop_front();
      vectors++;
      assert (ov === 1'b1) else begin
        miscompares++;
        $error("FAIL dut%0d_out_valid cyc=%0d got=%b exp=1", id, cyc, ov);
      end
      if (e.chk_vec) begin
        vectors++;
        assert (vec === e.vec) else begin
          miscompares++;
          $error("FAIL dut%0d_out_vec cyc=%0d got=%h exp=%h", id, cyc, vec, e.vec);
        end
      end
      vectors++;
      assert (ovf === e.ovf) else begin
        miscompares++;
        $error("FAIL dut%0d_acc_ovf cyc=%0d got=%b exp=%b", id, cyc, ovf, e.ovf);
      end
    end else begin
      assert (ov === 1'b0) else begin
        miscompares++;
        $error("FAIL dut%0d_spurious_valid cyc=%0d got=%b exp=0", id, cyc, ov);
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check_port(0, if0.out_valid, VW'(if0.out_vec), if0.acc_ovf);
      check_port(1, if1.out_valid, VW'(if1.out_vec), if1.acc_ovf);
      check_port(2, if2.out_valid, VW'(if2.out_vec), if2.acc_ovf);
    end
  end

  // Idle inputs carry junk to show in_* are ignored without in_valid.
  task automatic idle_all();
    if0.in_valid = 1'b0; if0.in_first = 1'($urandom_range(1)); if0.in_last = 1'($urandom_range(1));
    if0.a_vec = AW2'($urandom); if0.w = DW'($urandom);
    if1.in_valid = 1'b0; if1.in_first = 1'($urandom_range(1)); if1.in_last = 1'($urandom_range(1));
    if1.a_vec = AW2'($urandom); if1.w = DW'($urandom);
    if2.in_valid = 1'b0; if2.in_first = 1'($urandom_range(1)); if2.in_last = 1'($urandom_range(1));
    if2.a_vec = AW3'($urandom); if2.w = DW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic flush(input int n);
    repeat (n) tick();
  endtask

  task automatic beat0(input int a0, input int a1, input int w);
    exp_t e;
    @(posedge clk); #1;
    idle_all();
    if0.in_valid = 1'b1;
    if0.a_vec    = {a1[DW-1:0], a0[DW-1:0]};
    if0.w        = w[DW-1:0];
    e.due = cyc + 5; e.vec = pack3(a0 * w, a1 * w, 0); e.ovf = 1'b0; e.chk_vec = 1'b1;
    exp_q[0].push_back(e);
  endtask

  task automatic beat1(input int a0, input int a1, input int w, input bit first, input bit last);
    exp_t e;
    @(posedge clk); #1;
    idle_all();
    if1.in_valid = 1'b1;
    if1.in_first = first;
    if1.in_last  = last;
    if1.a_vec    = {a1[DW-1:0], a0[DW-1:0]};
    if1.w        = w[DW-1:0];
    if (first || !m_open) begin
      m_sum0 = a0 * w; m_sum1 = a1 * w; m_cnt = 1;
    end else begin
      m_sum0 += a0 * w; m_sum1 += a1 * w; m_cnt++;
    end
    if (last) begin
      e.due = cyc + 5; e.vec = pack3(m_sum0, m_sum1, 0);
      e.ovf = (m_cnt > (1 << (LS - 2 * DW)));
      e.chk_vec = !e.ovf;
      exp_q[1].push_back(e);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic beat2(input int a0, input int a1, input int a2, input int w);
    exp_t e;
    @(posedge clk); #1;
    idle_all();
    if2.in_valid = 1'b1;
    if2.a_vec    = {a2[DW-1:0], a1[DW-1:0], a0[DW-1:0]};
    if2.w        = w[DW-1:0];
    e.due = cyc + 5; e.vec = pack3(a0 * w, a1 * w, a2 * w); e.ovf = 1'b0; e.chk_vec = 1'b1;
    exp_q[2].push_back(e);
  endtask

  task automatic check_reset();
    vectors += 9;
    assert (if0.out_valid === 1'b0) else begin miscompares++; $error("FAIL rst_valid0 got=%b exp=0", if0.out_valid); end
    assert (if0.out_vec === '0) else begin miscompares++; $error("FAIL rst_vec0 got=%h exp=0", if0.out_vec); end
    assert (if0.acc_ovf === 1'b0) else begin miscompares++; $error("FAIL rst_ovf0 got=%b exp=0", if0.acc_ovf); end
    assert (if1.out_valid === 1'b0) else begin miscompares++; $error("FAIL rst_valid1 got=%b exp=0", if1.out_valid); end
    assert (if1.out_vec === '0) else begin miscompares++; $error("FAIL rst_vec1 got=%h exp=0", if1.out_vec); end
    assert (if1.acc_ovf === 1'b0) else begin miscompares++; $error("FAIL rst_ovf1 got=%b exp=0", if1.acc_ovf); end
    assert (if2.out_valid === 1'b0) else begin miscompares++; $error("FAIL rst_valid2 got=%b exp=0", if2.out_valid); end
    assert (if2.out_vec === '0) else begin miscompares++; $error("FAIL rst_vec2 got=%h exp=0", if2.out_vec); end
    assert (if2.acc_ovf === 1'b0) else begin miscompares++; $error("FAIL rst_ovf2 got=%b exp=0", if2.acc_ovf); end
  endtask

  // One-cycle reset; anything in flight is dropped from the reference too.
  task automatic do_reset();
    @(posedge clk); #1;
    idle_all();
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    m_open = 1'b0; m_cnt = 0; m_sum0 = 0; m_sum1 = 0;
  endtask

  initial begin
    int len;
    idle_all();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    checking = 1'b1;

    // Per-beat products, including sign-borrow corners.
    beat0(5, -3, -7);
    beat0(-8, -8, -8);
    beat0(-1, 0, 1);
    beat0(0, -1, 1);
    beat0(7, -8, 7);
    flush(8);

    // Four-beat group with an idle cycle inside.
    beat1(-8, 7, -8, 1'b1, 1'b0);
    beat1(-8, 7, -8, 1'b0, 1'b0);
    tick();
    beat1(-8, 7, -8, 1'b0, 1'b0);
    beat1(-8, 7, -8, 1'b0, 1'b1);
    flush(8);

    // Nine-beat group overflows the guard; single-beat group right behind.
    for (int i = 0; i < 9; i++) beat1(-8, 7, -8, i == 0, i == 8);
    beat1(3, 2, 2, 1'b1, 1'b1);
    flush(8);

    // Reset mid-group, then a stray last starts a clean single-beat group.
    beat1(1, 2, 3, 1'b1, 1'b0);
    beat1(4, 5, 6, 1'b0, 1'b0);
    do_reset();
    flush(8);
    beat1(3, -4, 5, 1'b0, 1'b1);
    flush(8);

    // Restart a group with first while one is open.
    beat1(7, 7, 7, 1'b1, 1'b0);
    beat1(-2, 3, -4, 1'b1, 1'b0);
    beat1(5, -6, 7, 1'b0, 1'b1);
    flush(8);

    // Random per-beat traffic with gaps.
    for (int i = 0; i < 300; i++) begin
      beat0(rs(), rs(), rs());
      if ($urandom_range(3) == 0) tick();
    end
    flush(8);

    // Random framed groups with gaps, stray lasts and occasional overflow.
    for (int g = 0; g < 60; g++) begin
      len = int'($urandom_range(1, 10));
      for (int b = 0; b < len; b++) begin
        beat1(rs(), rs(), rs(), (b == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0), b == len - 1);
        if ($urandom_range(3) == 0) tick();
      end
    end
    flush(8);

    // Three lanes back to back.
    for (int i = 0; i < 10000; i++) beat2(rs(), rs(), rs(), rs());
    flush(10);

    for (int i = 0; i < 3; i++) begin
      vectors++;
      assert (exp_q[i].size() === 0) else begin
        miscompares++;
        $error("FAIL dut%0d_pending got=%0d exp=0", i, exp_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
